ysyx_23060332_ctrl: RTL

Multi-cycle sequencer for the NPC core: fetch, decode, execute, memory and write-back become separate cycles, and each cycle's strobes to the datapath are gated. It holds the instruction register that feeds the decode unit. It performs valid/ready handshakes with the instruction-fetch and load/store memory ports. It gates register-file and PC writes so each committed instruction writes exactly once, and it halts on ebreak, illegal instruction or memory timeout.

---
 rtl/ysyx_23060332_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060332_ctrl.sv
// Multi-cycle sequencer for the NPC core: steps each instruction through fetch,
// decode, execute, memory and write-back, gating every datapath strobe.
module ysyx_23060332_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic [31:0] inst_o,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_is_ebreak,
    input  logic        dec_is_illegal,
    input  logic        dec_reg_wen,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        reg_wen_o,
    output logic        pc_wen,
    output logic        halt,
    output logic [1:0]  halt_code,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_FETCH_REQ  = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_DECODE     = 3'd2,
        S_EXEC       = 3'd3,
        S_MEM_REQ    = 3'd4,
        S_MEM_WAIT   = 3'd5,
        S_WB         = 3'd6,
        S_HALT       = 3'd7
    } state_e;

    localparam logic [1:0] HC_EBREAK  = 2'd1;
    localparam logic [1:0] HC_ILLEGAL = 2'd2;
    localparam logic [1:0] HC_TIMEOUT = 2'd3;

    // The watchdog holds the number of completed cycles in the current wait
    // state, so the last permitted waiting cycle is the one where it reads TIMEOUT-1.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [1:0]  code_q, code_d;
    logic [7:0]  wd_q, wd_d;
    logic [63:0] cycle_q, cycle_d;
    logic [63:0] instret_q, instret_d;
    logic        wd_expired;
    logic        in_wait;

    assign wd_expired = (wd_q == WD_LAST);
    assign in_wait    = (state_q == S_FETCH_REQ) || (state_q == S_FETCH_WAIT) ||
                        (state_q == S_MEM_REQ)   || (state_q == S_MEM_WAIT);

    // Handshakes: a request transfers on a rising edge where valid and ready are
    // both high; valid is a pure function of state so it never drops before
    // acceptance, and a response is only looked at in the state after the request.
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        code_d    = code_q;
        wd_d      = wd_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;

        if (state_q != S_HALT) begin
            cycle_d = cycle_q + 64'd1;
        end

        case (state_q)
            S_FETCH_REQ: begin
                if (ifu_req_ready) begin
                    state_d = S_FETCH_WAIT;
                end else if (wd_expired) begin
                    state_d = S_HALT;
                    code_d  = HC_TIMEOUT;
                end
            end
            S_FETCH_WAIT: begin
                if (ifu_rsp_valid) begin
                    state_d = S_DECODE;
                    inst_d  = ifu_rsp_inst;
                end else if (wd_expired) begin
                    state_d = S_HALT;
                    code_d  = HC_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (dec_is_ebreak) begin
                    state_d = S_HALT;
                    code_d  = HC_EBREAK;
                end else if (dec_is_illegal) begin
                    state_d = S_HALT;
                    code_d  = HC_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = (dec_is_load || dec_is_store) ? S_MEM_REQ : S_WB;
            end
            S_MEM_REQ: begin
                if (lsu_req_ready) begin
                    state_d = S_MEM_WAIT;
                end else if (wd_expired) begin
                    state_d = S_HALT;
                    code_d  = HC_TIMEOUT;
                end
            end
            S_MEM_WAIT: begin
                if (lsu_rsp_valid) begin
                    state_d = S_WB;
                end else if (wd_expired) begin
                    state_d = S_HALT;
                    code_d  = HC_TIMEOUT;
                end
            end
            S_WB: begin
                state_d   = S_FETCH_REQ;
                instret_d = instret_q + 64'd1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (state_d != state_q) begin
            wd_d = 8'd0;
        end else if (in_wait) begin
            wd_d = wd_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH_REQ;
            inst_q    <= 32'd0;
            code_q    <= 2'd0;
            wd_q      <= 8'd0;
            cycle_q   <= 64'd0;
            instret_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            code_q    <= code_d;
            wd_q      <= wd_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    // The reset state is FETCH_REQ, so the fetch request is masked by rst itself
    // to keep every strobe low while reset is held.
    assign ifu_req_valid = rst && (state_q == S_FETCH_REQ);
    assign lsu_req_valid = (state_q == S_MEM_REQ);
    assign pc_wen        = (state_q == S_WB);
    assign reg_wen_o     = (state_q == S_WB) && dec_reg_wen;
    assign halt          = (state_q == S_HALT);
    assign halt_code     = code_q;
    assign inst_o        = inst_q;
    assign cycle_cnt     = cycle_q;
    assign instret_cnt   = instret_q;

endmodule
